// File: rtl/ds3_frame_tx.sv
// rtl/ds3_frame_tx.sv - DS3 M-frame serial transmitter with overhead insertion, stuffing and P parity
module ds3_frame_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       pay_in,
  input  logic [6:0] stuff_req,
  input  logic       x_bit,
  output logic       sout,
  output logic       pay_req,
  output logic       frame_start,
  output logic [2:0] sub_idx,
  output logic [2:0] blk_idx
);
  // Position counters address the bit that the next rising edge loads onto sout.
  logic [6:0] bit_pos;
  logic [2:0] blk;
  logic [2:0] sub;
  logic [6:0] stuff_l;
  logic       x_l;
  logic       p_l;
  logic       par_acc;
  logic       frame_edge;
  logic       is_oh;
  logic       is_stuff;
  logic       oh_bit;
  logic       next_bit;

  always_comb begin
    frame_edge = (bit_pos == 7'd0) && (blk == 3'd0) && (sub == 3'd0);
    is_oh      = (bit_pos == 7'd0);
    is_stuff   = (bit_pos == 7'd1) && (blk == 3'd7) && stuff_l[sub];
    pay_req    = !is_oh && !is_stuff;
  end

  // The first X goes out on the same edge that samples x_bit, so it bypasses x_l.
  always_comb begin
    oh_bit = 1'b0;
    case (blk)
      3'd0: begin
        case (sub)
          3'd0:    oh_bit = x_bit;
          3'd1:    oh_bit = x_l;
          3'd2,
          3'd3:    oh_bit = p_l;
          3'd5:    oh_bit = 1'b1;
          default: oh_bit = 1'b0;
        endcase
      end
      3'd1, 3'd7: oh_bit = 1'b1;
      3'd3, 3'd5: oh_bit = 1'b0;
      default:    oh_bit = stuff_l[sub];
    endcase
    next_bit = is_oh ? oh_bit : (is_stuff ? 1'b0 : pay_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_pos <= 7'd0;
      blk     <= 3'd0;
      sub     <= 3'd0;
    end else if (bit_pos == 7'd84) begin
      bit_pos <= 7'd0;
      if (blk == 3'd7) begin
        blk <= 3'd0;
        sub <= (sub == 3'd6) ? 3'd0 : sub + 3'd1;
      end else begin
        blk <= blk + 3'd1;
      end
    end else begin
      bit_pos <= bit_pos + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sout        <= 1'b0;
      frame_start <= 1'b0;
      sub_idx     <= 3'd0;
      blk_idx     <= 3'd0;
    end else begin
      sout        <= next_bit;
      frame_start <= frame_edge;
      sub_idx     <= sub;
      blk_idx     <= blk;
    end
  end

  // Parity covers every payload slot including stuff bits; it is latched at the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stuff_l <= 7'd0;
      x_l     <= 1'b0;
      p_l     <= 1'b0;
      par_acc <= 1'b0;
    end else if (frame_edge) begin
      stuff_l <= stuff_req;
      x_l     <= x_bit;
      p_l     <= par_acc;
      par_acc <= 1'b0;
    end else if (!is_oh) begin
      par_acc <= par_acc ^ next_bit;
    end
  end

endmodule

// File: tb/tb_ds3_frame_tx.sv
// tb/tb_ds3_frame_tx.sv - scoreboard bench for ds3_frame_tx against a position-arithmetic frame model
module tb_ds3_frame_tx;
  localparam int FRAME = 4760;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pay_in = 1'b0;
  logic [6:0] stuff_req = 7'd0;
  logic       x_bit = 1'b0;
  logic       sout;
  logic       pay_req;
  logic       frame_start;
  logic [2:0] sub_idx;
  logic [2:0] blk_idx;

  ds3_frame_tx dut (
    .clk(clk), .reset(reset), .pay_in(pay_in), .stuff_req(stuff_req), .x_bit(x_bit),
    .sout(sout), .pay_req(pay_req), .frame_start(frame_start),
    .sub_idx(sub_idx), .blk_idx(blk_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sout;
    logic       fs;
    logic [2:0] sub;
    logic [2:0] blk;
    logic       pay;
  } item_t;

  item_t sb_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 0;

  // model state
  int       m_pos = 0;
  logic [6:0] m_stuff = 7'd0;
  logic     m_x = 1'b0;
  logic     m_p = 1'b0;
  logic     m_acc = 1'b0;

  // per-frame observations taken by the monitor
  int   fidx = -1;
  int   cnt = 0;
  int   pay_cnt = 0;
  int   paycnt_h[16];
  logic p1_h[16];
  logic p2_h[16];
  logic sb_h[16];
  logic psb_h[16];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        item_t e;
        item_t a;
        e = sb_q.pop_front();
        a = '{sout: sout, fs: frame_start, sub: sub_idx, blk: blk_idx, pay: pay_req};
        tests++;
        if (a !== e) begin
          fails++;
          if (fails < 20)
            $display("FAIL sb t=%0t: sout/fs/sub/blk/pay got %b/%b/%0d/%0d/%b expected %b/%b/%0d/%0d/%b",
                     $time, a.sout, a.fs, a.sub, a.blk, a.pay, e.sout, e.fs, e.sub, e.blk, e.pay);
        end
      end
      if (frame_start) begin
        if (fidx >= 0 && fidx < 16) paycnt_h[fidx] = pay_cnt;
        fidx++;
        cnt = 0;
        pay_cnt = int'(pay_req);
      end else begin
        cnt++;
        pay_cnt += int'(pay_req);
      end
      if (fidx >= 0 && fidx < 16) begin
        if (cnt == 2*680)          p1_h[fidx] = sout;
        if (cnt == 3*680)          p2_h[fidx] = sout;
        if (cnt == 2*680+7*85)     psb_h[fidx] = pay_req;
        if (cnt == 2*680+7*85+1)   sb_h[fidx] = sout;
      end
    end
  end

  // One line bit: drive inputs for the coming edge and push the model's view of the result.
  task automatic step(input logic [6:0] fst, input logic fx, input int mode);
    item_t it;
    int sub, blk, b, n2, sub2, blk2, b2;
    logic bitv, pv;
    if (m_pos == 0) begin
      stuff_req = fst;
      x_bit = fx;
      m_stuff = fst;
      m_x = fx;
      m_p = m_acc;
      m_acc = 1'b0;
    end else begin
      stuff_req = 7'($urandom);
      x_bit = 1'($urandom);
    end
    sub = m_pos / 680;
    blk = (m_pos % 680) / 85;
    b = m_pos % 85;
    pv = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom);
    if (b == 0) begin
      pay_in = 1'($urandom);
      if (blk == 0) begin
        if (sub < 2)      bitv = m_x;
        else if (sub < 4) bitv = m_p;
        else              bitv = (sub == 5);
      end else if (blk % 2 == 1) begin
        bitv = (blk == 1 || blk == 7);
      end else begin
        bitv = m_stuff[sub];
      end
    end else if (b == 1 && blk == 7 && m_stuff[sub]) begin
      pay_in = pv;
      bitv = 1'b0;
    end else begin
      pay_in = pv;
      bitv = pv;
      m_acc = m_acc ^ pv;
    end
    n2 = (m_pos + 1) % FRAME;
    sub2 = n2 / 680;
    blk2 = (n2 % 680) / 85;
    b2 = n2 % 85;
    it.sout = bitv;
    it.fs = (m_pos == 0);
    it.sub = 3'(sub);
    it.blk = 3'(blk);
    it.pay = (b2 != 0) && !(b2 == 1 && blk2 == 7 && m_stuff[sub2]);
    sb_q.push_back(it);
    m_pos = n2;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n, input logic [6:0] fst, input logic fx, input int mode);
    for (int i = 0; i < n; i++) step(fst, fx, mode);
  endtask

  initial begin
    reset = 1'b0;
    x_bit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sout", int'(sout), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_sub", int'(sub_idx), 0);
    chk("rst_blk", int'(blk_idx), 0);
    chk("rst_payreq", int'(pay_req), 0);
    #1;
    reset = 1'b1;
    mon_en = 1;
    run(FRAME, 7'd0, 1'b1, 0);             // F0: overhead pattern, x=1, P=0
    run(FRAME, 7'b0000100, 1'b0, 1);       // F1: stuff sub 2, all-ones payload
    run(FRAME, 7'd0, 1'b0, 1);             // F2: P carries F1 parity
    run(FRAME, 7'b0000001, 1'b0, 1);       // F3
    run(FRAME, 7'($urandom), 1'($urandom), 2); // F4
    run(3*680 + 4*85, 7'($urandom), 1'($urandom), 2); // F5 partial
    mon_en = 0;
    reset = 1'b0;
    #1;
    chk("mid_rst_sout", int'(sout), 0);
    chk("mid_rst_fs", int'(frame_start), 0);
    chk("mid_rst_sub", int'(sub_idx), 0);
    chk("mid_rst_blk", int'(blk_idx), 0);
    chk("mid_rst_payreq", int'(pay_req), 0);
    m_pos = 0;
    m_acc = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1;
    run(FRAME + 10, 7'($urandom), 1'($urandom), 2); // F6 after reset
    chk("sb_drain", sb_q.size(), 0);
    mon_en = 0;

    chk("f0_p1", int'(p1_h[0]), 0);
    chk("f0_p2", int'(p2_h[0]), 0);
    chk("f1_stuff_bit", int'(sb_h[1]), 0);
    chk("f1_stuff_payreq", int'(psb_h[1]), 0);
    chk("f1_paycnt", paycnt_h[1], 4703);
    chk("f2_p1", int'(p1_h[2]), 1);
    chk("f2_p2", int'(p2_h[2]), 1);
    chk("f2_paycnt", paycnt_h[2], 4704);
    chk("f3_p1", int'(p1_h[3]), 0);
    chk("f4_p1", int'(p1_h[4]), 1);
    chk("f4_p2", int'(p2_h[4]), 1);
    chk("frame_count", fidx, 7);
    chk("post_rst_p1", int'(p1_h[6]), 0);
    chk("post_rst_p2", int'(p2_h[6]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
